pipe_credit_fifo: RTL and testbench
===================================

// Module: pipe_credit_fifo
// PURPOSE
// - Consumer stage at the output of a fixed-latency, non-stallable data/status pipeline.
// - Absorbs every word the pipeline delivers into a small FIFO.
// - Re-presents the words as a valid/ready stream.
// - Returns issue credits to the source, counting words still in flight in the pipeline,
//   so the FIFO can never be overrun when the source obeys issue_ok_o.
// PARAMETERS
// - DATA_W    32  payload width
// - DEPTH     8   FIFO entries; any integer >= 2, not restricted to powers of two
// - PIPE_LAT  1   upstream pipeline latency in cycles; informational only, sizes the in-flight counter
// PORTS
// - clk          in   1                        clock; all state on rising edge
// - rst          in   1                        asynchronous reset, active-high
// - issue_i      in   1                        source launched one word into the upstream pipeline this cycle
// - issue_ok_o   out  1                        source may launch a word this cycle
// - in_data_i    in   DATA_W                   word arriving from the pipeline data output
// - in_valid_i   in   1                        pipeline status output: arriving word is valid
// - out_data_o   out  DATA_W                   FIFO head (first-word-fall-through)
// - out_valid_o  out  1                        FIFO non-empty
// - out_ready_i  in   1                        consumer accepts head this cycle
// - count_o      out  $clog2(DEPTH+1)          occupied entries
// - overflow_o   out  1                        sticky: an arriving word was dropped
// - proto_err_o  out  1                        sticky: word arrived with no issue outstanding
// BEHAVIOUR
// - Reset, asynchronous:
//   - Cleared: count, rd/wr pointers, in-flight counter, overflow_o, proto_err_o.
//   - Hence out_valid_o=0 and count_o=0.
//   - issue_ok_o is forced 0 while rst is high, then follows the credit rule below.
//   - Storage array is not reset.
//   - Reset mid-operation discards all buffered and in-flight words; no output glitch beyond the async clear.
// - Push: when in_valid_i=1.
//   - Write in_data_i at wr_ptr, advance wr_ptr.
//   - Pointers wrap DEPTH-1 -> 0 by compare, not by bit truncation.
// - Pop: when out_valid_o && out_ready_i. Advance rd_ptr.
//   - out_data_o is undefined/don't-care when out_valid_o=0.
// - Latency: a word pushed into an empty FIFO appears on out_data_o/out_valid_o one cycle later.
//   - No combinational in->out path.
// - Simultaneous push and pop:
//   - Both take effect and count is unchanged.
//   - This includes the count==DEPTH case, where the push is accepted because the pop frees the slot.
// - Push with count==DEPTH and no pop:
//   - The word is dropped and state is unchanged.
//   - overflow_o is set next cycle and held until reset.
// - In-flight counter (inflight, width $clog2(DEPTH+PIPE_LAT+2)):
//   - Next value: inflight + issue_i - in_valid_i.
//   - If in_valid_i=1 with inflight==0 and issue_i=0: inflight stays 0, proto_err_o is set sticky,
//     and the push itself still proceeds per the push rules.
//   - Saturates at its maximum; no wrap.
// - Credit rule, combinational from registered state:
//   - issue_ok_o = !rst && (count + inflight < DEPTH).
//   - issue_i while issue_ok_o=0 is still counted; the overrun then surfaces as overflow_o.
// - out_valid_o = (count != 0), registered-state derived.
// - count_o mirrors the internal count.
// TESTING
// - Reset release, idle -> out_valid_o=0, count_o=0, issue_ok_o=1, overflow_o=0, proto_err_o=0.
// - DEPTH=8, PIPE_LAT=3, ready held 0, source issues whenever issue_ok_o:
//   - exactly 8 issues occur;
//   - issue_ok_o drops after the 8th issue with inflight=3;
//   - count_o ends at 8; overflow_o stays 0.
// - Full FIFO, then push 0xA5 with out_ready_i=1 in the same cycle:
//   - head pops, 0xA5 is stored, count_o stays 8, no overflow;
//   - draining yields the original order followed by 0xA5.
// - Full FIFO, inject in_valid_i with ready=0:
//   - word dropped, overflow_o=1 next cycle and held;
//   - a later drain returns only the 8 original words.
// - in_valid_i pulsed with no prior issue_i -> proto_err_o=1, word still enqueued, count_o=1.
// - Wrap and reset: stream 20 words 0..19 through with random out_ready_i -> output order 0..19 exact;
//   async rst asserted mid-stream -> outputs clear immediately, issue_ok_o=0 until release.

Source files
------------

// File: rtl/pipe_credit_fifo.sv
// Credit-managed FIFO at the output of a fixed-latency, non-stallable pipeline.
// Each arriving word is buffered. Issue credits count both the words held here and the words still in flight.
module pipe_credit_fifo #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 8,
   parameter int PIPE_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_i,
   output logic                       issue_ok_o,
   input  logic [DATA_W-1:0]          in_data_i,
   input  logic                       in_valid_i,
   output logic [DATA_W-1:0]          out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   output logic                       proto_err_o
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int IF_W  = $clog2(DEPTH+PIPE_LAT+2);
   localparam int SUM_W = IF_W + 1;
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH-1);
   localparam logic [IF_W-1:0]  IF_MAX = '1;
   localparam logic [SUM_W-1:0] LIMIT  = SUM_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  count, count_next;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [IF_W-1:0]   inflight, inflight_next;
   logic              overflow, proto_err, proto_hit;
   logic              pop, accept, drop;

   assign pop    = out_valid_o && out_ready_i;
   // A push into a full FIFO still fits when the head leaves in the same cycle
   assign accept = in_valid_i && ((count != FULL) || pop);
   assign drop   = in_valid_i && !accept;

   assign out_valid_o = (count != '0);
   assign out_data_o  = mem[rd_ptr];
   assign count_o     = count;
   assign overflow_o  = overflow;
   assign proto_err_o = proto_err;
   assign issue_ok_o  = !rst && ((SUM_W'(count) + SUM_W'(inflight)) < LIMIT);

   always_comb begin
      count_next = count;
      case ({accept, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_comb begin
      inflight_next = inflight;
      proto_hit     = 1'b0;
      if (issue_i && !in_valid_i) begin
         if (inflight != IF_MAX)
            inflight_next = inflight + 1'b1;
      end else if (!issue_i && in_valid_i) begin
         if (inflight == '0)
            proto_hit = 1'b1;
         else
            inflight_next = inflight - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         inflight  <= '0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         count    <= count_next;
         inflight <= inflight_next;
         if (accept)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (drop)
            overflow <= 1'b1;
         if (proto_hit)
            proto_err <= 1'b1;
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= in_data_i;
   end

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Directed bench for pipe_credit_fifo with DEPTH=8 and PIPE_LAT=3.
// The upstream pipeline is modelled as a three-stage delay line.
module tb_pipe_credit_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_i;
   logic        issue_ok_o;
   logic [31:0] in_data_i;
   logic        in_valid_i;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [3:0]  count_o;
   logic        overflow_o;
   logic        proto_err_o;

   int vectors     = 0;
   int miscompares = 0;

   pipe_credit_fifo #(.DATA_W(32), .DEPTH(8), .PIPE_LAT(3)) dut (
      .clk(clk), .rst(rst),
      .issue_i(issue_i), .issue_ok_o(issue_ok_o),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .count_o(count_o), .overflow_o(overflow_o), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic iss, input logic vld, input logic [31:0] dat,
                                 input logic rdy);
      issue_i     = iss;
      in_valid_i  = vld;
      in_data_i   = dat;
      out_ready_i = rdy;
      tick();
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      issue_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   logic        pv [3];
   logic [31:0] pd [3];
   int          issued;
   int          sent;
   int          rcv;
   int          cyc;
   logic [31:0] exp_q [$];

   initial begin
      rst = 1'b1;
      issue_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      #2;
      check_output("issue_ok_in_reset", 32'(issue_ok_o), 32'd0);
      do_reset();

      check_output("rst_out_valid", 32'(out_valid_o), 32'd0);
      check_output("rst_count", 32'(count_o), 32'd0);
      check_output("rst_issue_ok", 32'(issue_ok_o), 32'd1);
      check_output("rst_overflow", 32'(overflow_o), 32'd0);
      check_output("rst_proto_err", 32'(proto_err_o), 32'd0);

      // Credit fill: source issues whenever allowed, consumer stalled
      for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pd[k] = '0; end
      issued = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8)
            check_output("issue_ok_drop_after_8th", 32'(issue_ok_o), 32'd0);
         in_valid_i  = pv[2];
         in_data_i   = pd[2];
         issue_i     = issue_ok_o;
         out_ready_i = 1'b0;
         pv[2] = pv[1]; pd[2] = pd[1];
         pv[1] = pv[0]; pd[1] = pd[0];
         pv[0] = issue_i; pd[0] = 32'h10 + 32'(issued);
         if (issue_i) issued++;
         tick();
      end
      issue_i = 1'b0; in_valid_i = 1'b0;
      check_output("credit_issue_count", 32'(issued), 32'd8);
      check_output("credit_count_full", 32'(count_o), 32'd8);
      check_output("credit_overflow", 32'(overflow_o), 32'd0);
      check_output("credit_issue_ok_full", 32'(issue_ok_o), 32'd0);
      check_output("credit_proto_err", 32'(proto_err_o), 32'd0);
      check_output("full_head", out_data_o, 32'h10);

      // Push while full, with a simultaneous pop
      apply_stimulus(1'b0, 1'b1, 32'hA5, 1'b1);
      issue_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      check_output("pushpop_count", 32'(count_o), 32'd8);
      check_output("pushpop_overflow", 32'(overflow_o), 32'd0);
      exp_q = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'hA5};
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("pushpop_drain%0d", i), out_data_o, exp_q[i]);
         apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      end
      out_ready_i = 1'b0;
      check_output("pushpop_empty", 32'(out_valid_o), 32'd0);

      // Overflow: push into a full FIFO with no pop
      do_reset();
      for (int i = 0; i < 8; i++)
         apply_stimulus(1'b0, 1'b1, 32'h20 + 32'(i), 1'b0);
      check_output("ovf_pre_count", 32'(count_o), 32'd8);
      check_output("ovf_pre_flag", 32'(overflow_o), 32'd0);
      apply_stimulus(1'b0, 1'b1, 32'hEE, 1'b0);
      in_valid_i = 1'b0;
      check_output("ovf_flag", 32'(overflow_o), 32'd1);
      check_output("ovf_count", 32'(count_o), 32'd8);
      tick(); tick();
      check_output("ovf_flag_held", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("ovf_drain%0d", i), out_data_o, 32'h20 + 32'(i));
         apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      end
      out_ready_i = 1'b0;
      check_output("ovf_drained_empty", 32'(out_valid_o), 32'd0);
      check_output("ovf_flag_sticky", 32'(overflow_o), 32'd1);

      // Arrival with nothing issued
      do_reset();
      check_output("proto_pre", 32'(proto_err_o), 32'd0);
      apply_stimulus(1'b0, 1'b1, 32'h55, 1'b0);
      in_valid_i = 1'b0;
      check_output("proto_flag", 32'(proto_err_o), 32'd1);
      check_output("proto_count", 32'(count_o), 32'd1);
      check_output("proto_valid", 32'(out_valid_o), 32'd1);
      check_output("proto_data", out_data_o, 32'h55);

      // Stream 0..19 with random back-pressure, exercising pointer wrap
      do_reset();
      sent = 0; rcv = 0; cyc = 0;
      while (rcv < 20 && cyc < 400) begin
         in_valid_i  = (sent < 20) && (count_o < 4'd8);
         in_data_i   = 32'(sent);
         issue_i     = 1'b0;
         out_ready_i = 1'($urandom_range(0, 1));
         if (out_valid_o && out_ready_i) begin
            check_output($sformatf("stream_word%0d", rcv), out_data_o, 32'(rcv));
            rcv++;
         end
         if (in_valid_i) sent++;
         tick();
         cyc++;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      check_output("stream_received", 32'(rcv), 32'd20);
      check_output("stream_overflow", 32'(overflow_o), 32'd0);
      check_output("stream_empty", 32'(out_valid_o), 32'd0);

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b0, 1'b1, 32'h40 + 32'(i), 1'b0);
      in_valid_i = 1'b0;
      check_output("midrst_pre_count", 32'(count_o), 32'd5);
      #3;
      rst = 1'b1;
      #1;
      check_output("midrst_valid", 32'(out_valid_o), 32'd0);
      check_output("midrst_count", 32'(count_o), 32'd0);
      check_output("midrst_issue_ok", 32'(issue_ok_o), 32'd0);
      tick();
      check_output("midrst_issue_ok_held", 32'(issue_ok_o), 32'd0);
      rst = 1'b0;
      #1;
      check_output("midrst_release_ok", 32'(issue_ok_o), 32'd1);
      check_output("midrst_release_proto", 32'(proto_err_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
